// File: rtl/soc_event_tx_pkg.sv
// -----------------------------------------------------------------------------
// soc_event_tx_pkg
// Shared definitions for the SoC event transmitter:
//   - default parameter constants for soc_event_tx
//   - FSM state encoding
//   - population-count helper used by the optional drop counter
// -----------------------------------------------------------------------------
package soc_event_tx_pkg;

    localparam int unsigned NB_SRC_DEF     = 32;
    localparam int unsigned EVNT_WIDTH_DEF = 8;
    localparam int unsigned DROP_CNT_W_DEF = 16;

    // IDLE: nothing in the output register; SEND: evt_valid_o high
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } evt_state_t;

    // Counts set bits of a vector zero-extended to the maximum source count
    function automatic logic [8:0] popcount256(input logic [255:0] v);
        logic [8:0] n;
        n = '0;
        for (int unsigned i = 0; i < 256; i++) begin
            n = n + 9'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/soc_evt_rr_pick.sv
// -----------------------------------------------------------------------------
// soc_evt_rr_pick
// Combinational round-robin picker. Searches the pending vector upward from
// (i_last + 1) modulo NB_SRC and returns the first set position.
// Ports:
//   i_pending  [NB_SRC-1:0]  pending event bits
//   i_last     [IDX_W-1:0]   index granted last time
//   o_valid                  at least one pending bit set
//   o_idx      [IDX_W-1:0]   winning source index (0 when o_valid is low)
// -----------------------------------------------------------------------------
module soc_evt_rr_pick #(
    parameter int unsigned NB_SRC = 32,
    parameter int unsigned IDX_W  = $clog2(NB_SRC)
) (
    input  logic [NB_SRC-1:0] i_pending,
    input  logic [IDX_W-1:0]  i_last,
    output logic              o_valid,
    output logic [IDX_W-1:0]  o_idx
);

    always_comb begin
        int unsigned       w_pos;
        logic [IDX_W-1:0]  w_cand;
        o_valid = 1'b0;
        o_idx   = '0;
        w_pos   = 0;
        w_cand  = '0;
        for (int unsigned i = 0; i < NB_SRC; i++) begin
            // i_last < NB_SRC, so a single wrap subtraction is enough
            w_pos = 32'(i_last) + i + 1;
            if (w_pos >= NB_SRC) begin
                w_pos = w_pos - NB_SRC;
            end
            w_cand = IDX_W'(w_pos);
            if (!o_valid && i_pending[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/soc_event_tx.sv
// -----------------------------------------------------------------------------
// soc_event_tx
// Collects single-cycle SoC peripheral event pulses into a pending register and
// streams the source indices, round-robin, over a valid/ready interface.
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   evt_i        [NB_SRC-1:0]     event pulses, one bit per source
//   evt_valid_o                   event ID valid
//   evt_ready_i                   receiver ready
//   evt_data_o   [EVNT_WIDTH-1:0] source index, zero-extended
//   pending_o    [NB_SRC-1:0]     pending register
//   err_o                         sticky drop flag
//   err_clr_i                     clears err_o and the drop counter
//   drop_cnt_o   [DROP_CNT_W-1:0] saturating dropped-event count
// Build option:
//   SOC_EVENT_TX_DROP_CNT_EN  defined -> drop counter present;
//                             undefined -> drop_cnt_o tied to zero.
// -----------------------------------------------------------------------------
module soc_event_tx
    import soc_event_tx_pkg::*;
#(
    parameter int unsigned NB_SRC     = NB_SRC_DEF,
    parameter int unsigned EVNT_WIDTH = EVNT_WIDTH_DEF,
    parameter int unsigned DROP_CNT_W = DROP_CNT_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NB_SRC-1:0]     evt_i,
    output logic                  evt_valid_o,
    input  logic                  evt_ready_i,
    output logic [EVNT_WIDTH-1:0] evt_data_o,
    output logic [NB_SRC-1:0]     pending_o,
    output logic                  err_o,
    input  logic                  err_clr_i,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);

    localparam int unsigned IDX_W = $clog2(NB_SRC);

    if (EVNT_WIDTH < IDX_W) begin : g_bad_width
        $error("soc_event_tx: EVNT_WIDTH too small for NB_SRC");
    end

    evt_state_t            r_state;
    evt_state_t            w_state_nxt;
    logic [NB_SRC-1:0]     r_pending;
    logic [NB_SRC-1:0]     w_grant_mask;
    logic [NB_SRC-1:0]     w_drops;
    logic [EVNT_WIDTH-1:0] r_data;
    logic [IDX_W-1:0]      r_last;
    logic [IDX_W-1:0]      w_pick_idx;
    logic                  w_pick_valid;
    logic                  w_load;
    logic                  r_err;

    soc_evt_rr_pick #(
        .NB_SRC (NB_SRC),
        .IDX_W  (IDX_W)
    ) u_rr_pick (
        .i_pending (r_pending),
        .i_last    (r_last),
        .o_valid   (w_pick_valid),
        .o_idx     (w_pick_idx)
    );

    // Next state; w_load means the winner enters the output register this edge
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (evt_ready_i) begin
                    if (w_pick_valid) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_grant_mask = w_load ? (NB_SRC'(1) << w_pick_idx) : '0;
    // A pulse on a bit being granted this edge re-pends rather than drops
    assign w_drops      = evt_i & r_pending & ~w_grant_mask;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_data    <= '0;
            r_last    <= IDX_W'(NB_SRC - 1);
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= (r_pending & ~w_grant_mask) | evt_i;
            if (w_load) begin
                r_data <= EVNT_WIDTH'(w_pick_idx);
                r_last <= w_pick_idx;
            end
            if (err_clr_i) begin
                r_err <= 1'b0;
            end else if (|w_drops) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef SOC_EVENT_TX_DROP_CNT_EN
    localparam int unsigned SUM_W = ((DROP_CNT_W > 9) ? DROP_CNT_W : 9) + 1;

    logic [DROP_CNT_W-1:0] r_drop_cnt;
    logic [SUM_W-1:0]      w_drop_sum;

    assign w_drop_sum = SUM_W'(r_drop_cnt) + SUM_W'(popcount256(256'(w_drops)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_drop_cnt <= '0;
        end else if (err_clr_i) begin
            r_drop_cnt <= '0;
        end else if (|w_drop_sum[SUM_W-1:DROP_CNT_W]) begin
            r_drop_cnt <= '1;
        end else begin
            r_drop_cnt <= w_drop_sum[DROP_CNT_W-1:0];
        end
    end

    assign drop_cnt_o = r_drop_cnt;
`else
    assign drop_cnt_o = '0;
`endif

    assign evt_valid_o = (r_state == ST_SEND);
    assign evt_data_o  = r_data;
    assign pending_o   = r_pending;
    assign err_o       = r_err;

    a_data_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (evt_valid_o && !evt_ready_i) |=> (evt_valid_o && $stable(evt_data_o)));

endmodule

// File: doc/soc_event_tx.md
SOC_EVENT_TX -- requirements
Module: soc_event_tx

Interface
REQ-001 Parameter NB_SRC, default 32, SHALL set the number of SoC peripheral event pulse sources (2..256).
REQ-002 Parameter EVNT_WIDTH, default 8, SHALL set the event ID width on the stream; EVNT_WIDTH >= clog2(NB_SRC).
REQ-003 Parameter DROP_CNT_W, default 16, SHALL set the dropped-event counter width.
REQ-004 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_ni  input  1  SHALL be the reset, asynchronous, active-low.
REQ-006 evt_i  input  NB_SRC  SHALL carry single-cycle event pulses, one bit per source.
REQ-007 evt_valid_o  output  1  SHALL flag a valid event ID on evt_data_o.
REQ-008 evt_ready_i  input  1  SHALL be the receiver's ready (cluster event unit FIFO not full).
REQ-009 evt_data_o  output  EVNT_WIDTH  SHALL carry the source index, zero-extended.
REQ-010 pending_o  output  NB_SRC  SHALL expose the pending register.
REQ-011 err_o  output  1  SHALL be a sticky drop flag.
REQ-012 err_clr_i  input  1  SHALL clear err_o and the drop counter.
REQ-013 drop_cnt_o  output  DROP_CNT_W  SHALL report dropped events.

Function
REQ-014 Pulse on evt_i[k] in cycle n SHALL set pending[k], visible in cycle n+1.
REQ-015 FSM SHALL have states IDLE (valid low) and SEND (valid high).
REQ-016 IDLE with pending != 0 SHALL load the round-robin winner index into the output register, clear its pending bit, and enter SEND; a pulse in cycle n gives evt_valid_o in cycle n+2 when otherwise idle.
REQ-017 Round-robin SHALL search upward from (last granted + 1) modulo NB_SRC; last granted resets to NB_SRC-1 so source 0 wins first.
REQ-018 In SEND, evt_valid_o and evt_data_o SHALL hold stable until evt_valid_o & evt_ready_i.
REQ-019 On handshake with pending != 0, the next winner SHALL load in the same edge (one event per cycle throughput); else FSM returns to IDLE.
REQ-020 A pulse on source k in the same cycle its pending bit is cleared by a grant SHALL leave pending[k] set (not a drop).
REQ-021 A pulse on source k while pending[k] is set and not being cleared SHALL be a drop; pending unchanged.
REQ-022 Drop counter SHALL add the number of drops in the cycle, saturating at all-ones; err_o SHALL set in the next cycle on any drop.
REQ-023 err_clr_i SHALL take priority over same-cycle drop increments (result zero, err_o low).
REQ-024 A source pulsing while its ID sits in the output register SHALL set pending again and be sent later.

Reset
REQ-025 Reset SHALL give evt_valid_o=0, evt_data_o=0, pending_o=0, err_o=0, drop_cnt_o=0, FSM IDLE, last granted=NB_SRC-1.
REQ-026 Reset mid-transfer SHALL discard the in-flight event and all pending events.

Configuration
REQ-027 Macro SOC_EVENT_TX_DROP_CNT_EN defined SHALL compile in the drop counter per REQ-022/023.
REQ-028 Without SOC_EVENT_TX_DROP_CNT_EN, drop_cnt_o SHALL be tied to zero with no counter flops; err_o and err_clr_i SHALL still work.

Structure
REQ-029 Package soc_event_tx_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-030 Round-robin pick SHALL be a combinational sub-module soc_evt_rr_pick (pending, last grant in; valid, index out).
REQ-031 Assertions SHALL check evt_data_o stability under backpressure and EVNT_WIDTH >= clog2(NB_SRC).

Verification
REQ-032 Pulse evt_i[5] at cycle 10, ready=1 -> valid in cycle 12, data=5, one cycle, pending_o=0 after.
REQ-033 Pulse evt_i[3], evt_i[7], evt_i[30] together, ready=1 -> IDs 3,7,30 on consecutive cycles.
REQ-034 ready=0 for 20 cycles with source 4 in flight -> data stays 4; second pulse on 4 sets pending; third pulse on 4 -> drop_cnt_o=1, err_o=1.
REQ-035 All 32 sources pulse twice while ready=0 -> drop_cnt_o=31 (first pulse of source 0 loaded, its second pulse re-pends), err_clr_i -> 0.
REQ-036 Source 0 pulses every cycle alongside source 1 -> grants alternate 0,1,0,1 (no starvation).
REQ-037 rst_ni low during SEND with pending=0x0F -> all outputs zero asynchronously; after release first grant is source 0.
